// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side, memory-side and status signals for mem_port_arbiter.
// master: arbiter view (drives readies, responses, memory request, busy).
// slave : environment view (requesters and backing memory).
`timescale 1ns/1ps
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic              i_ireq_valid;
    logic [ADDR_W-1:0] i_ireq_addr;
    logic              o_ireq_ready;
    logic              o_iresp_valid;
    logic [DATA_W-1:0] o_iresp_rdata;

    logic              i_dreq_valid;
    logic              i_dreq_we;
    logic [ADDR_W-1:0] i_dreq_addr;
    logic [DATA_W-1:0] i_dreq_wdata;
    logic [STRB_W-1:0] i_dreq_wstrb;
    logic              o_dreq_ready;
    logic              o_dresp_valid;
    logic [DATA_W-1:0] o_dresp_rdata;

    logic              o_mem_valid;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic [STRB_W-1:0] o_mem_wstrb;
    logic              i_mem_ready;
    logic              i_mem_rvalid;
    logic [DATA_W-1:0] i_mem_rdata;

    logic              o_busy_i;
    logic              o_busy_d;

    modport master (
        input  i_ireq_valid, i_ireq_addr,
        output o_ireq_ready, o_iresp_valid, o_iresp_rdata,
        input  i_dreq_valid, i_dreq_we, i_dreq_addr, i_dreq_wdata, i_dreq_wstrb,
        output o_dreq_ready, o_dresp_valid, o_dresp_rdata,
        output o_mem_valid, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb,
        input  i_mem_ready, i_mem_rvalid, i_mem_rdata,
        output o_busy_i, o_busy_d
    );

    modport slave (
        output i_ireq_valid, i_ireq_addr,
        input  o_ireq_ready, o_iresp_valid, o_iresp_rdata,
        output i_dreq_valid, i_dreq_we, i_dreq_addr, i_dreq_wdata, i_dreq_wstrb,
        input  o_dreq_ready, o_dresp_valid, o_dresp_rdata,
        input  o_mem_valid, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb,
        output i_mem_ready, i_mem_rvalid, i_mem_rdata,
        input  o_busy_i, o_busy_d
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one backing-memory port between instruction fetch (I) and load/store (D),
// one transaction in flight at a time: IDLE -> REQ -> RESP -> IDLE.
// Optional macro MEM_PORT_ARB_RR_EN: round-robin grant on contention
// (default build: fixed D-over-I priority).
//
// state   | meaning
// IDLE    | no transaction; readies offered to requesters
// REQ     | latched request presented to memory until i_mem_ready
// RESP    | waiting for i_mem_rvalid; routes response to owner
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    mem_port_arbiter_if.master  bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic              gnt_dside;
    logic              gnt_iside;

`ifdef MEM_PORT_ARB_RR_EN
    logic              last_grant_q, last_grant_d;

    // Round robin on contention: favour the side not granted last time.
    always_comb begin
        gnt_dside = bus.i_dreq_valid;
        if (bus.i_dreq_valid && bus.i_ireq_valid) begin
            gnt_dside = (last_grant_q == OWN_I);
        end
    end
`else
    assign gnt_dside = bus.i_dreq_valid;
`endif
    assign gnt_iside = ~gnt_dside;

    // State and latched request registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_I;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

`ifdef MEM_PORT_ARB_RR_EN
    // Remembers which side won the most recent acceptance.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_grant_q <= OWN_I;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    // Next-state, request latching and all handshake/memory outputs.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
`ifdef MEM_PORT_ARB_RR_EN
        last_grant_d = last_grant_q;
`endif
        bus.o_ireq_ready  = 1'b0;
        bus.o_dreq_ready  = 1'b0;
        bus.o_iresp_valid = 1'b0;
        bus.o_iresp_rdata = '0;
        bus.o_dresp_valid = 1'b0;
        bus.o_dresp_rdata = '0;
        bus.o_mem_valid   = 1'b0;
        bus.o_mem_we      = 1'b0;
        bus.o_mem_addr    = '0;
        bus.o_mem_wdata   = '0;
        bus.o_mem_wstrb   = '0;

        case (state_q)
            ST_IDLE: begin
                // Readies are held off while reset is asserted so nothing
                // looks accepted during reset.
                bus.o_dreq_ready = i_rst_n & bus.i_dreq_valid & gnt_dside;
                bus.o_ireq_ready = i_rst_n & bus.i_ireq_valid & gnt_iside;
                if (bus.o_dreq_ready) begin
                    owner_d = OWN_D;
                    we_d    = bus.i_dreq_we;
                    addr_d  = bus.i_dreq_addr;
                    wdata_d = bus.i_dreq_wdata;
                    wstrb_d = bus.i_dreq_wstrb;
                    state_d = ST_REQ;
`ifdef MEM_PORT_ARB_RR_EN
                    last_grant_d = OWN_D;
`endif
                end else if (bus.o_ireq_ready) begin
                    owner_d = OWN_I;
                    we_d    = 1'b0;
                    addr_d  = bus.i_ireq_addr;
                    wdata_d = '0;
                    wstrb_d = '0;
                    state_d = ST_REQ;
`ifdef MEM_PORT_ARB_RR_EN
                    last_grant_d = OWN_I;
`endif
                end
            end
            ST_REQ: begin
                bus.o_mem_valid = 1'b1;
                bus.o_mem_we    = we_q;
                bus.o_mem_addr  = addr_q;
                bus.o_mem_wdata = wdata_q;
                bus.o_mem_wstrb = wstrb_q;
                if (bus.i_mem_ready) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.i_mem_rvalid) begin
                    if (owner_q == OWN_D) begin
                        bus.o_dresp_valid = 1'b1;
                        bus.o_dresp_rdata = bus.i_mem_rdata;
                    end else begin
                        bus.o_iresp_valid = 1'b1;
                        bus.o_iresp_rdata = bus.i_mem_rdata;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.o_busy_i = (state_q != ST_IDLE) & (owner_q == OWN_I);
    assign bus.o_busy_d = (state_q != ST_IDLE) & (owner_q == OWN_D);
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single backing-memory port between the instruction-fetch side (I) and the load/store side (D).
- Handles one outstanding transaction at a time.
- Sequences each transaction through request, address-accept and response phases, and routes the response back to its owner.
- Drives the busy status that the pipeline hazard/stall logic consumes (for example, I-cache busy).

Parameters:
- ADDR_W, 32, address width for both requesters and the memory port.
- DATA_W, 32, data width; DATA_W/8 byte strobes.

Ports:
- i_clk  in  1  single clock for all state.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_ireq_valid  in  1  I-side read request.
- i_ireq_addr  in  ADDR_W  I-side address.
- o_ireq_ready  out  1  I request accepted this cycle.
- o_iresp_valid  out  1  I read data valid (1-cycle pulse).
- o_iresp_rdata  out  DATA_W  I read data.
- i_dreq_valid  in  1  D-side request.
- i_dreq_we  in  1  1 = write, 0 = read.
- i_dreq_addr  in  ADDR_W  D-side address.
- i_dreq_wdata  in  DATA_W  D-side write data.
- i_dreq_wstrb  in  DATA_W/8  D-side byte enables.
- o_dreq_ready  out  1  D request accepted this cycle.
- o_dresp_valid  out  1  D response (read data or write ack), 1-cycle pulse.
- o_dresp_rdata  out  DATA_W  D read data.
- o_mem_valid  out  1  memory request valid.
- o_mem_we  out  1  memory write.
- o_mem_addr  out  ADDR_W  memory address.
- o_mem_wdata  out  DATA_W  memory write data.
- o_mem_wstrb  out  DATA_W/8  memory byte enables.
- i_mem_ready  in  1  memory accepts request.
- i_mem_rvalid  in  1  memory response (reads and writes both acknowledged).
- i_mem_rdata  in  DATA_W  memory read data.
- o_busy_i  out  1  I transaction in flight.
- o_busy_d  out  1  D transaction in flight.

Behaviour:
- **Reset.** i_rst_n low, asynchronously:
  - state = IDLE, owner = I, last_grant = I.
  - Latched request registers are cleared.
  - All outputs are 0.
  - Reset mid-transaction abandons the transaction with no response pulse; the memory side is reset by the same reset.
- **States.** IDLE, REQ, RESP.
- **IDLE, ready generation (combinational).**
  - o_dreq_ready = i_dreq_valid & grant_d.
  - o_ireq_ready = i_ireq_valid & grant_i.
  - Fixed priority: grant_d = 1 when D is valid; grant_i = ~i_dreq_valid.
  - At most one ready is high in any cycle.
- **IDLE, acceptance.** On a valid&ready handshake:
  - The accepted request is latched. For I: we = 0, wstrb = 0, wdata = 0.
  - owner is set to the accepted side, last_grant updated, next state = REQ.
  - With no request, the arbiter stays in IDLE.
- **REQ.**
  - o_mem_valid = 1; the mem fields are driven from the latched registers and held stable until i_mem_ready.
  - On i_mem_ready, next state = RESP.
  - Ready outputs are 0 in REQ and RESP.
- **RESP.**
  - On i_mem_rvalid, the response pulses for exactly that cycle: o_iresp_valid when owner = I, o_dresp_valid when owner = D.
  - The selected resp_rdata = i_mem_rdata (combinational pass-through); the other side's rdata = 0.
  - Next state = IDLE.
- **Stray responses.** i_mem_rvalid in IDLE or REQ is ignored.
- **Simultaneous ready/rvalid.** i_mem_ready and i_mem_rvalid may arrive in the same cycle as REQ exits. The rvalid is not accepted until RESP; the memory guarantees rvalid comes at least 1 cycle after ready.
- **Latency and throughput.**
  - Minimum latency, with zero-wait memory (ready in the first REQ cycle, rvalid the next cycle): accept at cycle 0, o_mem_valid at cycle 1, response at cycle 2, next accept at cycle 3.
  - Peak throughput is one transaction per 3 cycles.
- **Busy outputs.** o_busy_i = (state != IDLE) & owner == I; o_busy_d likewise for D. Both are combinational from registered state.
- **Requester contract.** A requester keeps valid and its fields stable until ready. Deasserting valid before ready withdraws the request legally.

Optional Feature:
- Macro: MEM_PORT_ARB_RR_EN.
- Defined: when both requesters are valid in IDLE, the grant goes to the side opposite last_grant (round robin). A single valid requester is always granted.
- Undefined: fixed D-over-I priority as above, and last_grant is unused, optimized away.

Test Plan:
- Reset state: hold i_rst_n = 0 with both requesters valid -> all outputs 0, no ready. Release -> o_dreq_ready = 1 in the first cycle.
- Single I read: addr 0x100 and memory returns 0xDEADBEEF (ready at once, rvalid +1) -> o_ireq_ready at cycle 0, o_mem_valid with addr 0x100 at cycle 1, o_iresp_valid with 0xDEADBEEF at cycle 2, o_busy_i high over cycles 1–2.
- D write with stalls: addr 0x200, wdata 0x12345678, wstrb 0x3; memory holds i_mem_ready low for 3 cycles -> mem fields stable for 4 cycles, o_dresp_valid pulses once, o_iresp_valid stays 0.
- Contention, macro undefined: both valid continuously for 4 transactions -> all 4 grants go to D, and I is granted only after D drops. Macro defined -> grants alternate D, I, D, I.
- Reset in RESP: assert i_rst_n = 0 while waiting for rvalid -> outputs go to 0 immediately (asynchronously), no resp pulse. After release, a later stray i_mem_rvalid in IDLE produces no response.
- Stray rvalid and zero-wait back-to-back: i_mem_rvalid pulsed in IDLE -> ignored. Back-to-back I requests -> accepts at cycles 0 and 3, responses at cycles 2 and 5.
